// File: rtl/joint_step_shaper_if.sv
`default_nettype none
// ============================================================================
//  Module      : joint_step_shaper_if
//  Description : Signal bundle between the step generator / host side and the
//                joint_step_shaper output stage.
//                  enable, dir_in, stp_in, clear_overrun : requests into shaper
//                  step_out, dir_out                     : driver pins
//                  position, busy, overrun               : status to host
//                Modport "master" is the requester side, "slave" the shaper.
//  Revision    : 1.0 - initial release
// ============================================================================
interface joint_step_shaper_if;
    logic               enable;
    logic               dir_in;
    logic               stp_in;
    logic               clear_overrun;
    logic               step_out;
    logic               dir_out;
    logic signed [31:0] position;
    logic               busy;
    logic               overrun;

    modport master (
        output enable, dir_in, stp_in, clear_overrun,
        input  step_out, dir_out, position, busy, overrun
    );

    modport slave (
        input  enable, dir_in, stp_in, clear_overrun,
        output step_out, dir_out, position, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/joint_step_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : joint_step_shaper
//  Description : Converts a toggling step request and raw direction bit into
//                driver-legal STEP/DIR with fixed pulse width, DIR setup time
//                and minimum low time. One-deep pending slot, sticky overrun
//                flag and optional signed step-position counter.
//  Ports       : clk    - system clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - joint_step_shaper_if.slave (requests in, STEP/DIR
//                         pins and status out)
//  Parameters  : PULSE_LEN - STEP high cycles
//                DIR_SETUP - cycles from DIR change to STEP rise
//                DIR_HOLD  - minimum STEP low cycles after a pulse
//  Macro       : JOINT_STEP_SHAPER_POSITION_EN - builds the position counter;
//                when undefined, position is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module joint_step_shaper #(
    parameter int PULSE_LEN = 100,
    parameter int DIR_SETUP = 50,
    parameter int DIR_HOLD  = 50
) (
    input wire               clk,
    input wire               rst_n,
    joint_step_shaper_if.slave bus
);

    // Counter reload values: each phase runs from N-1 down to 0.
    localparam logic [15:0] C_PULSE_LD = 16'(PULSE_LEN - 1);
    localparam logic [15:0] C_SETUP_LD = 16'(DIR_SETUP - 1);
    localparam logic [15:0] C_HOLD_LD  = 16'(DIR_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_stp_prev;
    logic        r_step_out;
    logic        r_dir_out;
    logic        r_slot_vld;
    logic        r_slot_dir;
    logic        r_busy;
    logic        r_overrun;

    state_t      w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic        w_step_nxt;
    logic        w_dir_nxt;
    logic        w_slot_vld_nxt;
    logic        w_slot_dir_nxt;
    logic        w_ovr_set;
    logic        w_req;
    logic        w_last;
    logic        w_slot_live;
    logic        w_consume;
    logic        w_start;
    logic        w_start_dir;

    assign w_req       = bus.enable & (bus.stp_in ^ r_stp_prev);
    assign w_last      = (r_cnt == 16'd0);
    // A disabled joint forgets its queued step.
    assign w_slot_live = r_slot_vld & bus.enable;
    // Last HOLD cycle: the slot (or a fresh request) is started this cycle.
    assign w_consume   = (r_state == S_HOLD) & w_last;

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_step_nxt     = r_step_out;
        w_dir_nxt      = r_dir_out;
        w_slot_vld_nxt = w_slot_live;
        w_slot_dir_nxt = r_slot_dir;
        w_ovr_set      = 1'b0;
        w_start        = 1'b0;
        w_start_dir    = bus.dir_in;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_start     = 1'b1;
                    w_start_dir = bus.dir_in;
                end
            end
            S_SETUP: begin
                if (w_last) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = C_PULSE_LD;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_PULSE: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD_LD;
                    w_step_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_HOLD: begin
                if (w_last) begin
                    if (w_slot_live) begin
                        // Queued step goes out; a same-cycle request refills.
                        w_start        = 1'b1;
                        w_start_dir    = r_slot_dir;
                        w_slot_vld_nxt = w_req;
                        w_slot_dir_nxt = bus.dir_in;
                    end else if (w_req) begin
                        w_start     = 1'b1;
                        w_start_dir = bus.dir_in;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = 1'b0;
            end
        endcase

        // Requests arriving mid-sequence go to the slot or are dropped.
        if (w_req && (r_state != S_IDLE) && !w_consume) begin
            if (w_slot_live) begin
                w_ovr_set = 1'b1;
            end else begin
                w_slot_vld_nxt = 1'b1;
                w_slot_dir_nxt = bus.dir_in;
            end
        end

        // Start rule: same direction pulses at once, reversal inserts SETUP.
        if (w_start) begin
            if (w_start_dir == r_dir_out) begin
                w_state_nxt = S_PULSE;
                w_cnt_nxt   = C_PULSE_LD;
                w_step_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_SETUP;
                w_cnt_nxt   = C_SETUP_LD;
                w_dir_nxt   = w_start_dir;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_stp_prev <= 1'b0;
            r_step_out <= 1'b0;
            r_dir_out  <= 1'b0;
            r_slot_vld <= 1'b0;
            r_slot_dir <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stp_prev <= bus.stp_in;
            r_step_out <= w_step_nxt;
            r_dir_out  <= w_dir_nxt;
            r_slot_vld <= w_slot_vld_nxt;
            r_slot_dir <= w_slot_dir_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            // Clear wins over a same-cycle drop.
            r_overrun  <= bus.clear_overrun ? 1'b0 : (r_overrun | w_ovr_set);
        end
    end

`ifdef JOINT_STEP_SHAPER_POSITION_EN
    logic signed [31:0] r_position;

    // Counted on the edge where STEP rises, using the DIR already on the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_position <= 32'sd0;
        end else if (w_step_nxt && !r_step_out) begin
            r_position <= r_dir_out ? (r_position + 32'sd1) : (r_position - 32'sd1);
        end
    end

    assign bus.position = r_position;
`else
    assign bus.position = 32'sd0;
`endif

    assign bus.step_out = r_step_out;
    assign bus.dir_out  = r_dir_out;
    assign bus.busy     = r_busy;
    assign bus.overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_joint_step_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_joint_step_shaper
//  Description : Directed self-checking bench for joint_step_shaper with
//                PULSE_LEN=4, DIR_SETUP=3, DIR_HOLD=2. Inputs change 1 time
//                unit after the rising edge; outputs are sampled there too.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_joint_step_shaper;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   rises;
    int   base;
    logic prev_step;

    joint_step_shaper_if bus ();

    joint_step_shaper #(
        .PULSE_LEN (4),
        .DIR_SETUP (3),
        .DIR_HOLD  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts STEP rising edges seen at falling clock edges.
    initial begin
        rises     = 0;
        prev_step = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.step_out === 1'b1 && prev_step !== 1'b1) rises++;
            prev_step = bus.step_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected position: the counter only exists when the macro is defined.
    function automatic logic [31:0] pexp(input int v);
`ifdef JOINT_STEP_SHAPER_POSITION_EN
        return 32'(v);
`else
        return 32'(v) & 32'h0;
`endif
    endfunction

    initial begin
        n_vec             = 0;
        n_err             = 0;
        rst_n             = 1'b0;
        bus.enable        = 1'b1;
        bus.dir_in        = 1'b0;
        bus.stp_in        = 1'b0;
        bus.clear_overrun = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset values
        chk("rst_step", 32'(bus.step_out), 32'd0);
        chk("rst_dir",  32'(bus.dir_out),  32'd0);
        chk("rst_pos",  bus.position,      32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_ovr",  32'(bus.overrun),  32'd0);

        // T1: single rise, dir 0 -> 4-cycle pulse, position -1
        bus.dir_in = 1'b0;
        bus.stp_in = 1'b1;
        tick();
        chk("t1_pos", bus.position, pexp(-1));
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t1_step%0d", i), 32'(bus.step_out), 32'((i <= 4) ? 1 : 0));
            chk($sformatf("t1_dir%0d", i), 32'(bus.dir_out), 32'd0);
            tick();
        end
        chk("t1_busy_hold", 32'(bus.busy), 32'd1);
        tick();
        chk("t1_busy_idle", 32'(bus.busy), 32'd0);

        // T2: direction change -> DIR at n+1, STEP at n+4
        bus.dir_in = 1'b1;
        bus.stp_in = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("t2_step%0d", i), 32'(bus.step_out), 32'((i >= 4 && i <= 7) ? 1 : 0));
            chk($sformatf("t2_busy%0d", i), 32'(bus.busy), 32'((i <= 9) ? 1 : 0));
            chk($sformatf("t2_dir%0d", i), 32'(bus.dir_out), 32'd1);
            if (i == 3) chk("t2_pos_before", bus.position, pexp(-1));
            if (i == 4) chk("t2_pos_after", bus.position, pexp(0));
        end

        // T3: three consecutive edges -> start, queue, drop
        base = rises;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3_step%0d", i), 32'(bus.step_out),
                32'(((i >= 1 && i <= 4) || (i >= 7 && i <= 10)) ? 1 : 0));
            chk($sformatf("t3_ovr%0d", i), 32'(bus.overrun), 32'((i >= 3) ? 1 : 0));
            if (i <= 2) bus.stp_in = ~bus.stp_in;
            tick();
        end
        chk("t3_rises", 32'(rises - base), 32'd2);
        chk("t3_pos", bus.position, pexp(2));
        chk("t3_busy", 32'(bus.busy), 32'd0);
        bus.clear_overrun = 1'b1;
        tick();
        bus.clear_overrun = 1'b0;
        chk("t3_ovr_clr", 32'(bus.overrun), 32'd0);

        // T4: request on last HOLD with slot full, then clear vs drop
        base = rises;
        for (int i = 0; i < 22; i++) begin
            chk($sformatf("t4_step%0d", i), 32'(bus.step_out),
                32'(((i >= 1 && i <= 4) || (i >= 7 && i <= 10) || (i >= 13 && i <= 16)) ? 1 : 0));
            chk($sformatf("t4_ovr%0d", i), 32'(bus.overrun), 32'd0);
            if (i == 0 || i == 1 || i == 6 || i == 8) bus.stp_in = ~bus.stp_in;
            bus.clear_overrun = (i == 8);
            tick();
        end
        bus.clear_overrun = 1'b0;
        chk("t4_rises", 32'(rises - base), 32'd3);
        chk("t4_pos", bus.position, pexp(5));
        chk("t4_busy", 32'(bus.busy), 32'd0);

        // T5: enable dropped mid-PULSE with slot full
        base = rises;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("t5_step%0d", i), 32'(bus.step_out), 32'((i >= 1 && i <= 4) ? 1 : 0));
            chk($sformatf("t5_busy%0d", i), 32'(bus.busy), 32'((i >= 1 && i <= 6) ? 1 : 0));
            bus.enable = (i < 2);
            if (i == 0 || i == 1 || i == 8 || i == 10) bus.stp_in = ~bus.stp_in;
            tick();
        end
        chk("t5_rises", 32'(rises - base), 32'd1);
        chk("t5_pos", bus.position, pexp(6));
        bus.enable = 1'b1;
        tick();
        chk("t5_reen_busy", 32'(bus.busy), 32'd0);

        // T6: asynchronous reset mid-PULSE (stp_in is high here: falling edge)
        base = rises;
        bus.stp_in = 1'b0;
        tick();
        chk("t6_step_hi", 32'(bus.step_out), 32'd1);
        chk("t6_pos_pre", bus.position, pexp(7));
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_step_async", 32'(bus.step_out), 32'd0);
        chk("t6_pos_rst", bus.position, 32'd0);
        chk("t6_dir_rst", 32'(bus.dir_out), 32'd0);
        chk("t6_busy_rst", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("t6_idle_step%0d", i), 32'(bus.step_out), 32'd0);
            chk($sformatf("t6_idle_busy%0d", i), 32'(bus.busy), 32'd0);
        end

        // T7: ten negative steps
        base = rises;
        bus.dir_in = 1'b0;
        for (int s = 0; s < 10; s++) begin
            bus.stp_in = ~bus.stp_in;
            tick();
            chk($sformatf("t7_step%0d", s), 32'(bus.step_out), 32'd1);
            repeat (7) tick();
        end
        chk("t7_rises", 32'(rises - base), 32'd10);
        chk("t7_pos", bus.position, pexp(-10));
        chk("t7_dir", 32'(bus.dir_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
